// File: rtl/idexe_operand_stage_pkg.sv
// ============================================================================
// idexe_operand_stage_pkg : shared pipeline types, widths and forward encodings
// Rev 1.0
// ============================================================================
`default_nettype none

package idexe_operand_stage_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned REG_W  = 5;
  localparam int unsigned ALUC_W = 4;

  typedef enum logic [1:0] {
    FWD_RF   = 2'd0,
    FWD_EXE  = 2'd1,
    FWD_MALU = 2'd2,
    FWD_MMO  = 2'd3
  } fwd_sel_e;

  // Youngest producer wins; r0 is hardwired zero and never forwarded.
  function automatic fwd_sel_e fwd_select(
    input logic [REG_W-1:0] src,
    input logic             ewreg,
    input logic             em2reg,
    input logic [REG_W-1:0] edestreg,
    input logic             mwreg,
    input logic             mm2reg,
    input logic [REG_W-1:0] mdestreg
  );
    fwd_sel_e sel;
    sel = FWD_RF;
    if (src != '0) begin
      if (ewreg && !em2reg && (edestreg == src))
        sel = FWD_EXE;
      else if (mwreg && !mm2reg && (mdestreg == src))
        sel = FWD_MALU;
      else if (mwreg && mm2reg && (mdestreg == src))
        sel = FWD_MMO;
    end
    return sel;
  endfunction

endpackage

`default_nettype wire

// File: rtl/idexe_operand_stage_fwd_mux.sv
// ============================================================================
// fwd_mux : 4:1 operand select driven by a forward code
// Rev 1.0
// ============================================================================
`default_nettype none

module fwd_mux
  import idexe_operand_stage_pkg::*;
(
  input  logic [1:0]        sel,
  input  logic [DATA_W-1:0] in_rf,
  input  logic [DATA_W-1:0] in_exe,
  input  logic [DATA_W-1:0] in_malu,
  input  logic [DATA_W-1:0] in_mmo,
  output logic [DATA_W-1:0] y
);

  always_comb begin
    y = in_rf;
    case (sel)
      FWD_EXE:  y = in_exe;
      FWD_MALU: y = in_malu;
      FWD_MMO:  y = in_mmo;
      default:  y = in_rf;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/idexe_operand_stage.sv
// ============================================================================
// idexe_operand_stage : ID/EX pipeline register with operand forwarding and
// load-use stall detection. Rev 1.0
// ============================================================================
`default_nettype none

module idexe_operand_stage
  import idexe_operand_stage_pkg::*;
(
  input  logic              clk,
  input  logic              clrn,
  input  logic [REG_W-1:0]  drs,
  input  logic [REG_W-1:0]  drt,
  input  logic              dusers,
  input  logic              dusert,
  input  logic [DATA_W-1:0] dqa,
  input  logic [DATA_W-1:0] dqb,
  input  logic [DATA_W-1:0] dimm32,
  input  logic              daluimm,
  input  logic              dwreg,
  input  logic              dm2reg,
  input  logic              dwmem,
  input  logic [ALUC_W-1:0] daluc,
  input  logic [REG_W-1:0]  ddestreg,
  input  logic              dflush,
  input  logic [DATA_W-1:0] ealu_r,
  input  logic              mwreg,
  input  logic              mm2reg,
  input  logic [REG_W-1:0]  mdestreg,
  input  logic [DATA_W-1:0] malu_r,
  input  logic [DATA_W-1:0] mmo,
  output logic [DATA_W-1:0] eqa,
  output logic [DATA_W-1:0] eqb,
  output logic [DATA_W-1:0] eimm32,
  output logic              ealuimm,
  output logic              ewreg,
  output logic              em2reg,
  output logic              ewmem,
  output logic [ALUC_W-1:0] ealuc,
  output logic [REG_W-1:0]  edestreg,
  output logic              stall
);

  logic [1:0]        fwd_a;
  logic [1:0]        fwd_b;
  logic [DATA_W-1:0] opa;
  logic [DATA_W-1:0] opb;
  logic              bubble;

  assign fwd_a = fwd_select(drs, ewreg, em2reg, edestreg, mwreg, mm2reg, mdestreg);
  assign fwd_b = fwd_select(drt, ewreg, em2reg, edestreg, mwreg, mm2reg, mdestreg);

  // A load in EXE cannot supply data yet; hold ID one cycle so it reaches MEM.
  assign stall = ewreg && em2reg && (edestreg != '0) &&
                 ((dusers && (edestreg == drs)) || (dusert && (edestreg == drt)));

  assign bubble = stall || dflush;

  fwd_mux u_fwd_rs (
    .sel     (fwd_a),
    .in_rf   (dqa),
    .in_exe  (ealu_r),
    .in_malu (malu_r),
    .in_mmo  (mmo),
    .y       (opa)
  );

  fwd_mux u_fwd_rt (
    .sel     (fwd_b),
    .in_rf   (dqb),
    .in_exe  (ealu_r),
    .in_malu (malu_r),
    .in_mmo  (mmo),
    .y       (opb)
  );

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      eqa      <= '0;
      eqb      <= '0;
      eimm32   <= '0;
      ealuimm  <= 1'b0;
      ewreg    <= 1'b0;
      em2reg   <= 1'b0;
      ewmem    <= 1'b0;
      ealuc    <= '0;
      edestreg <= '0;
    end else if (bubble) begin
      eqa      <= '0;
      eqb      <= '0;
      eimm32   <= '0;
      ealuimm  <= 1'b0;
      ewreg    <= 1'b0;
      em2reg   <= 1'b0;
      ewmem    <= 1'b0;
      ealuc    <= '0;
      edestreg <= '0;
    end else begin
      eqa      <= opa;
      eqb      <= opb;
      eimm32   <= dimm32;
      ealuimm  <= daluimm;
      ewreg    <= dwreg;
      em2reg   <= dm2reg;
      ewmem    <= dwmem;
      ealuc    <= daluc;
      edestreg <= ddestreg;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_idexe_operand_stage.sv
// ============================================================================
// tb_idexe_operand_stage : directed bench with a reference model of the stage
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_idexe_operand_stage;

  logic        clk = 1'b0;
  logic        clrn = 1'b0;
  logic [4:0]  drs = '0, drt = '0, ddestreg = '0, mdestreg = '0;
  logic        dusers = 1'b0, dusert = 1'b0, daluimm = 1'b0;
  logic        dwreg = 1'b0, dm2reg = 1'b0, dwmem = 1'b0, dflush = 1'b0;
  logic        mwreg = 1'b0, mm2reg = 1'b0;
  logic [3:0]  daluc = '0;
  logic [31:0] dqa = '0, dqb = '0, dimm32 = '0, ealu_r = '0, malu_r = '0, mmo = '0;

  logic [31:0] eqa, eqb, eimm32;
  logic        ealuimm, ewreg, em2reg, ewmem, stall;
  logic [3:0]  ealuc;
  logic [4:0]  edestreg;

  int n_vec = 0;
  int n_err = 0;

  idexe_operand_stage dut (
    .clk(clk), .clrn(clrn), .drs(drs), .drt(drt), .dusers(dusers), .dusert(dusert),
    .dqa(dqa), .dqb(dqb), .dimm32(dimm32), .daluimm(daluimm), .dwreg(dwreg),
    .dm2reg(dm2reg), .dwmem(dwmem), .daluc(daluc), .ddestreg(ddestreg), .dflush(dflush),
    .ealu_r(ealu_r), .mwreg(mwreg), .mm2reg(mm2reg), .mdestreg(mdestreg),
    .malu_r(malu_r), .mmo(mmo), .eqa(eqa), .eqb(eqb), .eimm32(eimm32),
    .ealuimm(ealuimm), .ewreg(ewreg), .em2reg(em2reg), .ewmem(ewmem),
    .ealuc(ealuc), .edestreg(edestreg), .stall(stall)
  );

  always #5 clk = ~clk;

  // Reference model: the instruction currently held in EXE.
  logic [31:0] m_qa, m_qb, m_imm;
  logic        m_aluimm, m_wreg, m_m2reg, m_wmem;
  logic [3:0]  m_aluc;
  logic [4:0]  m_dest;

  function automatic logic [31:0] ref_operand(input logic [4:0] src, input logic [31:0] rf);
    if (src == 5'd0) return rf;
    if (m_wreg && !m_m2reg && m_dest == src) return ealu_r;
    if (mwreg && mdestreg == src) return mm2reg ? mmo : malu_r;
    return rf;
  endfunction

  function automatic logic ref_stall();
    if (!(m_wreg && m_m2reg) || m_dest == 5'd0) return 1'b0;
    return (dusers && m_dest == drs) || (dusert && m_dest == drt);
  endfunction

  always @(posedge clk or negedge clrn) begin
    if (!clrn || ref_stall() || dflush) begin
      m_qa <= 0; m_qb <= 0; m_imm <= 0; m_aluimm <= 0;
      m_wreg <= 0; m_m2reg <= 0; m_wmem <= 0; m_aluc <= 0; m_dest <= 0;
    end else begin
      m_qa <= ref_operand(drs, dqa); m_qb <= ref_operand(drt, dqb);
      m_imm <= dimm32; m_aluimm <= daluimm; m_wreg <= dwreg; m_m2reg <= dm2reg;
      m_wmem <= dwmem; m_aluc <= daluc; m_dest <= ddestreg;
    end
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    check("estate",
          {19'd0, eqa, eqb, eimm32, ealuimm, ewreg, em2reg, ewmem, ealuc, edestreg},
          {19'd0, m_qa, m_qb, m_imm, m_aluimm, m_wreg, m_m2reg, m_wmem, m_aluc, m_dest});
    check("stall", {127'd0, stall}, {127'd0, ref_stall()});
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic id_instr(input logic [4:0] rs, input logic [4:0] rt, input logic ur,
                          input logic ut, input logic w, input logic m2r,
                          input logic [4:0] dest);
    drs = rs; drt = rt; dusers = ur; dusert = ut;
    dwreg = w; dm2reg = m2r; dwmem = 1'b0; ddestreg = dest;
    dflush = 1'b0; daluimm = 1'b0; daluc = 4'h0; dimm32 = 32'h0;
  endtask

  initial begin
    #12;
    clrn = 1'b1;
    step();

    // Plain pass-through of ID fields
    id_instr(5'd1, 5'd2, 1, 1, 1, 0, 5'd9);
    dqa = 32'h1111; dqb = 32'h2222; dimm32 = 32'hFFFF_FF80; daluimm = 1; daluc = 4'hA;
    step();
    check("pass_eqa", {96'd0, eqa}, {96'd0, 32'h1111});
    check("pass_imm", {96'd0, eimm32}, {96'd0, 32'hFFFF_FF80});
    check("pass_ctl", {119'd0, ealuimm, ewreg, ealuc, edestreg}, {119'd0, 1'b1, 1'b1, 4'hA, 5'd9});

    // EXE forward: E holds add r3
    id_instr(5'd0, 5'd0, 0, 0, 1, 0, 5'd3);
    step();
    id_instr(5'd3, 5'd0, 1, 0, 1, 0, 5'd5);
    ealu_r = 32'h0000_00AA; dqa = 32'h11;
    step();
    check("exe_fwd_eqa", {96'd0, eqa}, {96'd0, 32'hAA});

    // E and M both target r5: EXE wins
    id_instr(5'd0, 5'd5, 0, 1, 0, 0, 5'd0);
    mwreg = 1; mm2reg = 0; mdestreg = 5'd5; malu_r = 32'h2; ealu_r = 32'h1; dqb = 32'h77;
    step();
    check("exe_priority_eqb", {96'd0, eqb}, {96'd0, 32'h1});

    // MEM ALU forward (E is no longer writing r5)
    id_instr(5'd5, 5'd0, 1, 0, 0, 0, 5'd0);
    dqa = 32'h99;
    step();
    check("malu_fwd_eqa", {96'd0, eqa}, {96'd0, 32'h2});
    mwreg = 0;

    // Load-use: lw r4 in E, ID reads rt=4
    id_instr(5'd0, 5'd0, 0, 0, 1, 1, 5'd4);
    step();
    id_instr(5'd0, 5'd4, 0, 1, 1, 0, 5'd6);
    dqb = 32'h1234;
    #1;
    check("loaduse_stall", {127'd0, stall}, {127'd0, 1'b1});
    step();
    check("loaduse_bubble", {118'd0, ewreg, em2reg, ewmem, edestreg, eqb[1:0]}, 128'd0);
    mwreg = 1; mm2reg = 1; mdestreg = 5'd4; mmo = 32'hDEAD_BEEF;
    #1;
    check("loaduse_release", {127'd0, stall}, {127'd0, 1'b0});
    step();
    check("mmo_fwd_eqb", {96'd0, eqb}, {96'd0, 32'hDEAD_BEEF});
    mwreg = 0; mm2reg = 0;

    // dusers=0: a matching load must not stall
    id_instr(5'd0, 5'd0, 0, 0, 1, 1, 5'd8);
    step();
    id_instr(5'd8, 5'd0, 0, 0, 1, 0, 5'd2);
    #1;
    check("no_stall_unused", {127'd0, stall}, {127'd0, 1'b0});
    step();

    // Flush squashes writes
    id_instr(5'd1, 5'd1, 0, 0, 1, 0, 5'd7);
    dwmem = 1; dflush = 1;
    step();
    check("flush_bubble", {121'd0, ewreg, ewmem, edestreg}, 128'd0);

    // Stall and flush together
    id_instr(5'd0, 5'd0, 0, 0, 1, 1, 5'd10);
    step();
    id_instr(5'd10, 5'd0, 1, 0, 1, 0, 5'd11);
    dflush = 1;
    step();
    check("stall_flush", {122'd0, ewreg, edestreg}, 128'd0);

    // r0 never forwarded / never stalls
    id_instr(5'd0, 5'd0, 0, 0, 1, 0, 5'd0);
    step();
    id_instr(5'd0, 5'd0, 1, 1, 1, 1, 5'd0);
    ealu_r = 32'h55; dqa = 32'h0;
    #1;
    check("r0_stall", {127'd0, stall}, {127'd0, 1'b0});
    step();
    check("r0_eqa", {96'd0, eqa}, {96'd0, 32'h0});
    id_instr(5'd0, 5'd0, 1, 1, 1, 0, 5'd0);
    #1;
    check("r0_load_stall", {127'd0, stall}, {127'd0, 1'b0});
    step();

    // Mixed traffic over a small register set, checked by the model
    for (int i = 0; i < 40; i++) begin
      id_instr(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom), 1'($urandom),
               1'($urandom), 1'($urandom), 5'($urandom_range(0, 3)));
      dflush = ($urandom_range(0, 7) == 0);
      dqa = $urandom; dqb = $urandom; dimm32 = $urandom; daluc = 4'($urandom);
      ealu_r = $urandom; malu_r = $urandom; mmo = $urandom;
      mwreg = 1'($urandom); mm2reg = 1'($urandom); mdestreg = 5'($urandom_range(0, 3));
      step();
    end

    // Asynchronous reset mid-run with E writing
    id_instr(5'd0, 5'd0, 0, 0, 1, 0, 5'd12);
    dqa = 32'h5A5A; dflush = 0;
    step();
    check("pre_reset_ewreg", {127'd0, ewreg}, {127'd0, 1'b1});
    clrn = 1'b0;
    #1;
    check("async_reset", {19'd0, eqa, eqb, eimm32, ealuimm, ewreg, em2reg, ewmem, ealuc, edestreg},
          128'd0);
    check("reset_stall", {127'd0, stall}, {127'd0, 1'b0});
    step();
    clrn = 1'b1;
    id_instr(5'd0, 5'd0, 0, 0, 1, 0, 5'd13);
    step();
    check("resume", {122'd0, ewreg, edestreg}, {122'd0, 1'b1, 5'd13});
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/idexe_operand_stage.md
IDEXE_OPERAND_STAGE -- requirements
Module: idexe_operand_stage

Interface
REQ-001 SHALL have: clk  in  1  single pipeline clock, all state on rising edge.
REQ-002 SHALL have: clrn  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have: drs, drt  in  5 each  ID source register numbers.
REQ-004 SHALL have: dusers, dusert  in  1 each  ID instruction reads rs / rt.
REQ-005 SHALL have: dqa, dqb  in  32 each  register-file read data.
REQ-006 SHALL have: dimm32  in  32  extended immediate; daluimm  in  1  immediate-operand select.
REQ-007 SHALL have: dwreg, dm2reg, dwmem  in  1 each; daluc  in  4; ddestreg  in  5  ID control and destination.
REQ-008 SHALL have: dflush  in  1  squash ID instruction (branch/jump redirect).
REQ-009 SHALL have: ealu_r  in  32  EXE-stage ALU result, combinational from downstream ALU.
REQ-010 SHALL have: mwreg, mm2reg  in  1 each; mdestreg  in  5; malu_r, mmo  in  32 each  MEM-stage state and data.
REQ-011 SHALL have: eqa, eqb, eimm32  out  32 each; ealuimm, ewreg, em2reg, ewmem  out  1 each; ealuc  out  4; edestreg  out  5  registered ID/EX outputs.
REQ-012 SHALL have: stall  out  1  combinational; freezes PC and IF/ID register.

Function
REQ-013 SHALL compute per operand (rs->eqa path, rt->eqb path) a forward select, priority order: EXE hit (ewreg & !em2reg & edestreg==src & src!=0) -> ealu_r; else MEM ALU hit (mwreg & !mm2reg & mdestreg==src & src!=0) -> malu_r; else MEM load hit (mwreg & mm2reg & mdestreg==src & src!=0) -> mmo; else dqa/dqb.
REQ-014 SHALL assert stall when ewreg & em2reg & edestreg!=0 & ((dusers & edestreg==drs) | (dusert & edestreg==drt)).
REQ-015 SHALL, on each rising edge with stall=0 and dflush=0, load forwarded operands, dimm32, daluimm, daluc, ddestreg, dwreg, dm2reg, dwmem into the E outputs; latency exactly one cycle.
REQ-016 SHALL, on an edge with stall=1 or dflush=1, load a bubble: ewreg=ewmem=em2reg=ealuimm=0, ealuc=0, edestreg=0, eqa=eqb=eimm32=0.
REQ-017 SHALL treat stall and dflush asserted together as a bubble; dflush takes no extra effect.
REQ-018 SHALL limit a load-use stall to one cycle: after the bubble the load is in MEM and REQ-013 MEM load path supplies mmo.
REQ-019 SHALL never forward for source register 0; eqa/eqb equal dqa/dqb (zero) in that case.
REQ-020 SHALL apply forwarding regardless of dusers/dusert; those inputs gate only stall.

Reset
REQ-021 SHALL, while clrn=0, drive every registered output to 0 asynchronously; stall therefore reads 0.
REQ-022 SHALL, on clrn rising mid-operation, resume at the next edge with no residual bubble or forward state.

Structure
REQ-023 SHALL place forward-select encodings (FWD_RF=0, FWD_EXE=1, FWD_MALU=2, FWD_MMO=3) and ALUC width in the shared pipeline package.
REQ-024 SHALL use one sub-module fwd_mux (32-bit 4:1 select driven by a 2-bit code), instantiated for rs and rt paths.

Verification
REQ-025 SHALL test: clrn=0 mid-run with ewreg=1 -> all outputs 0 immediately, stall=0.
REQ-026 SHALL test: E holds add r3 (ewreg=1, edestreg=3), ID rs=3, ealu_r=0x0000_00AA, dqa=0x11 -> next edge eqa=0xAA.
REQ-027 SHALL test: E and M both target r5 (ealu_r=0x1, malu_r=0x2), ID rt=5 -> eqb=0x1 (EXE priority).
REQ-028 SHALL test: E holds lw r4 (em2reg=1), ID dusert=1 rt=4 -> stall=1 one cycle, bubble loaded; next cycle mwreg=mm2reg=1, mmo=0xDEAD_BEEF -> eqb=0xDEAD_BEEF, stall=0.
REQ-029 SHALL test: dflush=1 with dwreg=dwmem=1 -> next edge ewreg=ewmem=0, edestreg=0.
REQ-030 SHALL test: ewreg=1, edestreg=0, ID rs=0, ealu_r=0x55, dqa=0 -> eqa=0, stall=0.
